// File: rtl/board_move_engine_if.sv
// Request/response bundle between the game controller and the move engine.
interface board_move_engine_if #(
    parameter int unsigned SIZE    = 4,
    parameter int unsigned TILE_W  = 20,
    parameter int unsigned SCORE_W = 21
);
    localparam int unsigned BOARD_W = SIZE * SIZE * TILE_W;

    logic               start;
    logic [1:0]         dir;
    logic [BOARD_W-1:0] board_in;
    logic               busy;
    logic               done;
    logic [BOARD_W-1:0] board_out;
    logic               moved;
    logic [SCORE_W-1:0] score_add;

    modport master (
        output start, dir, board_in,
        input  busy, done, board_out, moved, score_add
    );

    modport slave (
        input  start, dir, board_in,
        output busy, done, board_out, moved, score_add
    );
endinterface

// File: rtl/board_move_engine.sv
// Sequential 2048 slide/merge engine: one row or column of an SIZE x SIZE board per clock.
module board_move_engine #(
    parameter int unsigned SIZE    = 4,
    parameter int unsigned TILE_W  = 20,
    parameter int unsigned SCORE_W = 21
) (
    input  logic               clk,
    input  logic               rst,
    board_move_engine_if.slave bus
);
    localparam int          SZ    = SIZE;
    localparam int unsigned K_W   = $clog2(SIZE);
    localparam int unsigned SUM_W = ((SCORE_W > TILE_W + 3) ? SCORE_W : TILE_W + 3) + 1;

    typedef logic [SIZE*SIZE-1:0][TILE_W-1:0] board_t;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

    state_e             state_q, state_d;
    board_t             work_q, work_d;
    board_t             in_q, in_d;
    board_t             board_out_q, board_out_d;
    logic [1:0]         dir_q, dir_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [SCORE_W-1:0] acc_q, acc_d;
    logic [SCORE_W-1:0] score_add_q, score_add_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               moved_q, moved_d;

    logic [TILE_W-1:0]  ln [SIZE];
    logic [SUM_W-1:0]   line_score;
    logic [SUM_W-1:0]   acc_sum;
    logic [SCORE_W-1:0] acc_sat;
    board_t             work_upd;

    // Slide/merge line k of the work board; ln[0] is the tile nearest the destination edge.
    always_comb begin
        logic [TILE_W-1:0] merged;
        merged     = '0;
        line_score = '0;
        work_upd   = work_q;
        for (int i = 0; i < SZ; i++) ln[i] = '0;

        for (int kk = 0; kk < SZ; kk++) begin
            for (int i = 0; i < SZ; i++) begin
                if (k_q == K_W'(kk)) begin
                    case (dir_q)
                        2'd0:    ln[i] = work_q[kk*SZ + i];
                        2'd1:    ln[i] = work_q[i*SZ + kk];
                        2'd2:    ln[i] = work_q[kk*SZ + (SZ-1-i)];
                        default: ln[i] = work_q[(SZ-1-i)*SZ + kk];
                    endcase
                end
            end
        end

        // Bubble empties toward the tail; SIZE-1 passes fully compact the line.
        for (int p = 0; p < SZ - 1; p++) begin
            for (int i = 0; i < SZ - 1; i++) begin
                if (ln[i] == '0) begin
                    ln[i]   = ln[i+1];
                    ln[i+1] = '0;
                end
            end
        end

        // Zeroing the partner keeps a fresh merge result from pairing again.
        for (int i = 0; i < SZ - 1; i++) begin
            if (ln[i] != '0 && ln[i] == ln[i+1] && !ln[i][TILE_W-1]) begin
                merged     = {ln[i][TILE_W-2:0], 1'b0};
                ln[i]      = merged;
                ln[i+1]    = '0;
                line_score = line_score + SUM_W'(merged);
            end
        end

        for (int p = 0; p < SZ - 1; p++) begin
            for (int i = 0; i < SZ - 1; i++) begin
                if (ln[i] == '0) begin
                    ln[i]   = ln[i+1];
                    ln[i+1] = '0;
                end
            end
        end

        for (int kk = 0; kk < SZ; kk++) begin
            for (int i = 0; i < SZ; i++) begin
                if (k_q == K_W'(kk)) begin
                    case (dir_q)
                        2'd0:    work_upd[kk*SZ + i]         = ln[i];
                        2'd1:    work_upd[i*SZ + kk]         = ln[i];
                        2'd2:    work_upd[kk*SZ + (SZ-1-i)]  = ln[i];
                        default: work_upd[(SZ-1-i)*SZ + kk]  = ln[i];
                    endcase
                end
            end
        end
    end

    // Saturating score accumulation.
    always_comb begin
        acc_sum = SUM_W'(acc_q) + line_score;
        acc_sat = (acc_sum > SUM_W'({SCORE_W{1'b1}})) ? {SCORE_W{1'b1}} : SCORE_W'(acc_sum);
    end

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        in_d        = in_q;
        dir_d       = dir_q;
        k_d         = k_q;
        acc_d       = acc_q;
        board_out_d = board_out_q;
        moved_d     = moved_q;
        score_add_d = score_add_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    work_d  = bus.board_in;
                    in_d    = bus.board_in;
                    dir_d   = bus.dir;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                work_d = work_upd;
                acc_d  = acc_sat;
                k_d    = k_q + K_W'(1);
                // Results are loaded on the way into DONE so they are valid with done.
                if (k_q == K_W'(SIZE - 1)) begin
                    k_d         = '0;
                    state_d     = DONE;
                    board_out_d = work_upd;
                    moved_d     = (work_upd != in_q);
                    score_add_d = acc_sat;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            work_q      <= '0;
            in_q        <= '0;
            dir_q       <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            board_out_q <= '0;
            moved_q     <= 1'b0;
            score_add_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            in_q        <= in_d;
            dir_q       <= dir_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            board_out_q <= board_out_d;
            moved_q     <= moved_d;
            score_add_q <= score_add_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.board_out = board_out_q;
    assign bus.moved     = moved_q;
    assign bus.score_add = score_add_q;
endmodule

// File: tb/tb_board_move_engine.sv
// Self-checking bench for board_move_engine: directed 2048 cases plus random boards against a queue-based model.
module tb_board_move_engine;
    localparam int N  = 4;
    localparam int TW = 20;
    localparam int SW = 21;

    typedef logic [N*N-1:0][TW-1:0] board_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    board_move_engine_if #(.SIZE(N), .TILE_W(TW), .SCORE_W(SW)) bus ();

    board_move_engine #(.SIZE(N), .TILE_W(TW), .SCORE_W(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Board index of element i of line k; element 0 sits at the destination edge.
    function automatic int pos(input logic [1:0] d, input int k, input int i);
        case (d)
            2'd0:    return k*N + i;
            2'd1:    return i*N + k;
            2'd2:    return k*N + (N-1-i);
            default: return (N-1-i)*N + k;
        endcase
    endfunction

    function automatic void model(input board_t b, input logic [1:0] d,
                                  output board_t res, output logic mv, output logic [SW-1:0] sc);
        longint total;
        longint q[$];
        longint o[$];
        longint v;
        total = 0;
        res   = '0;
        for (int k = 0; k < N; k++) begin
            q.delete();
            o.delete();
            for (int i = 0; i < N; i++)
                if (b[pos(d, k, i)] != 0) q.push_back(longint'(b[pos(d, k, i)]));
            while (q.size() > 0) begin
                v = q.pop_front();
                if (q.size() > 0 && q[0] == v && v < (longint'(1) << (TW-1))) begin
                    v = q.pop_front();
                    o.push_back(2*v);
                    total += 2*v;
                end else begin
                    o.push_back(v);
                end
            end
            for (int i = 0; i < N; i++)
                res[pos(d, k, i)] = (i < o.size()) ? TW'(o[i]) : '0;
        end
        mv = (res != b);
        sc = (total > longint'((1 << SW) - 1)) ? '1 : SW'(total);
    endfunction

    function automatic logic [TW-1:0] rand_tile();
        int r;
        r = $urandom_range(0, 9);
        if (r < 3)       return '0;
        else if (r == 9) return TW'(1) << $urandom_range(17, 19);
        else             return TW'(1) << $urandom_range(1, 4);
    endfunction

    function automatic board_t rand_board();
        board_t b;
        for (int j = 0; j < N*N; j++) b[j] = rand_tile();
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one move, scramble inputs after the start edge, wait (bounded) for done.
    task automatic run_move(input board_t b, input logic [1:0] d,
                            output board_t bo, output logic mv, output logic [SW-1:0] sc,
                            output int lat, output logic done_after, output logic busy_after);
        bus.board_in = b;
        bus.dir      = d;
        bus.start    = 1'b1;
        step();
        bus.start    = 1'b0;
        bus.board_in = rand_board();
        bus.dir      = 2'($urandom);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        bo = bus.board_out;
        mv = bus.moved;
        sc = bus.score_add;
        step();
        done_after = bus.done;
        busy_after = bus.busy;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.start    = 1'b1;
        bus.dir      = 2'd0;
        bus.board_in = rand_board();
        step();
        step();
        rst       = 1'b0;
        bus.start = 1'b0;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        n_checks++; if (bus.board_out !== '0) begin n_fail++; $display("FAIL reset_board_out: got %h expected 0", bus.board_out); end
        n_checks++; if (bus.moved !== 1'b0) begin n_fail++; $display("FAIL reset_moved: got %b expected 0", bus.moved); end
        n_checks++; if (bus.score_add !== '0) begin n_fail++; $display("FAIL reset_score: got %h expected 0", bus.score_add); end
        step();
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_over_start: busy got %b expected 0", bus.busy); end
    endtask

    task automatic test_directed();
        int         din  [9][16];
        int         dexp [9][16];
        logic [1:0] dirs [9];
        logic       emv  [9];
        int         esc  [9];
        board_t     b, e, bo;
        logic       mv, da, ba;
        logic [SW-1:0] sc;
        int         lat;
        din[0] = '{0:2, 1:2, 2:2, 3:2, default:0};
        din[1] = '{0:2, 1:2, 2:4, default:0};
        din[2] = '{0:2, 1:2, 2:4, default:0};
        din[3] = '{4:2, 12:2, default:0};
        din[4] = '{4:2, 12:2, default:0};
        din[5] = '{2,4,8,16, 16,8,4,2, 2,4,8,16, 16,8,4,2};
        din[6] = '{0:'h80000, 1:'h80000, default:0};
        din[7] = '{1:'h80000, 3:'h80000, default:0};
        din[8] = '{default:'h40000};
        dexp[0] = '{0:4, 1:4, default:0};
        dexp[1] = '{0:4, 1:4, default:0};
        dexp[2] = '{2:4, 3:4, default:0};
        dexp[3] = '{0:4, default:0};
        dexp[4] = '{12:4, default:0};
        dexp[5] = '{2,4,8,16, 16,8,4,2, 2,4,8,16, 16,8,4,2};
        dexp[6] = '{0:'h80000, 1:'h80000, default:0};
        dexp[7] = '{0:'h80000, 1:'h80000, default:0};
        dexp[8] = '{0:'h80000, 1:'h80000, 4:'h80000, 5:'h80000,
                    8:'h80000, 9:'h80000, 12:'h80000, 13:'h80000, default:0};
        dirs = '{2'd0, 2'd0, 2'd2, 2'd1, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
        emv  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        esc  = '{8, 4, 4, 4, 4, 0, 0, 0, 'h1FFFFF};
        for (int c = 0; c < 9; c++) begin
            for (int j = 0; j < N*N; j++) begin
                b[j] = TW'(din[c][j]);
                e[j] = TW'(dexp[c][j]);
            end
            run_move(b, dirs[c], bo, mv, sc, lat, da, ba);
            n_checks++; if (bo !== e) begin n_fail++; $display("FAIL dir_case%0d_board: got %h expected %h", c, bo, e); end
            n_checks++; if (mv !== emv[c]) begin n_fail++; $display("FAIL dir_case%0d_moved: got %b expected %b", c, mv, emv[c]); end
            n_checks++; if (sc !== SW'(esc[c])) begin n_fail++; $display("FAIL dir_case%0d_score: got %h expected %h", c, sc, SW'(esc[c])); end
            n_checks++; if (lat !== N) begin n_fail++; $display("FAIL dir_case%0d_latency: got %0d expected %0d", c, lat, N); end
            n_checks++; if (da !== 1'b0) begin n_fail++; $display("FAIL dir_case%0d_done_pulse: got %b expected 0", c, da); end
        end
    endtask

    task automatic test_random();
        board_t        b, e, bo;
        logic          emv, mv, da, ba;
        logic [SW-1:0] esc, sc;
        logic [1:0]    d;
        int            lat;
        for (int it = 0; it < 150; it++) begin
            b = rand_board();
            d = 2'($urandom);
            model(b, d, e, emv, esc);
            run_move(b, d, bo, mv, sc, lat, da, ba);
            n_checks++; if (bo !== e) begin n_fail++; $display("FAIL rand%0d_board dir %0d: got %h expected %h", it, d, bo, e); end
            n_checks++; if (mv !== emv) begin n_fail++; $display("FAIL rand%0d_moved: got %b expected %b", it, mv, emv); end
            n_checks++; if (sc !== esc) begin n_fail++; $display("FAIL rand%0d_score: got %h expected %h", it, sc, esc); end
            n_checks++; if (lat !== N) begin n_fail++; $display("FAIL rand%0d_latency: got %0d expected %0d", it, lat, N); end
        end
    endtask

    task automatic test_back_to_back();
        board_t        b, e, bo;
        logic          emv, mv, da, ba;
        logic [SW-1:0] esc, sc;
        int            lat;
        for (int it = 0; it < 4; it++) begin
            b = rand_board();
            model(b, 2'(it), e, emv, esc);
            run_move(b, 2'(it), bo, mv, sc, lat, da, ba);
            n_checks++; if (bo !== e) begin n_fail++; $display("FAIL b2b%0d_board: got %h expected %h", it, bo, e); end
            n_checks++; if (lat !== N) begin n_fail++; $display("FAIL b2b%0d_latency: got %0d expected %0d", it, lat, N); end
            n_checks++; if (ba !== 1'b0) begin n_fail++; $display("FAIL b2b%0d_busy_after: got %b expected 0", it, ba); end
        end
    endtask

    task automatic test_busy_ignore();
        board_t        a, bb, e, bo;
        logic          emv;
        logic [SW-1:0] esc, sc;
        int            pulses, first;
        a  = rand_board();
        a[0] = TW'(2);
        bb = rand_board();
        model(a, 2'd0, e, emv, esc);
        bus.board_in = a;
        bus.dir      = 2'd0;
        bus.start    = 1'b1;
        step();
        bus.start    = 1'b0;
        step();
        bus.board_in = bb;
        bus.dir      = 2'd2;
        bus.start    = 1'b1;
        step();
        bus.start    = 1'b0;
        pulses = 0;
        first  = -1;
        bo     = '0;
        sc     = '0;
        for (int c = 3; c < 3 + 3*N; c++) begin
            if (bus.done === 1'b1) begin
                pulses++;
                if (first < 0) begin
                    first = c - 1;
                    bo = bus.board_out;
                    sc = bus.score_add;
                end
            end
            step();
        end
        n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL ignore_pulses: got %0d expected 1", pulses); end
        n_checks++; if (first !== N) begin n_fail++; $display("FAIL ignore_latency: got %0d expected %0d", first, N); end
        n_checks++; if (bo !== e) begin n_fail++; $display("FAIL ignore_board: got %h expected %h", bo, e); end
        n_checks++; if (sc !== esc) begin n_fail++; $display("FAIL ignore_score: got %h expected %h", sc, esc); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ignore_busy_end: got %b expected 0", bus.busy); end
    endtask

    task automatic test_rst_midrun();
        board_t        b, e, bo;
        logic          emv, mv, da, ba;
        logic [SW-1:0] esc, sc;
        int            lat, pulses;
        b = rand_board();
        b[0] = TW'(4);
        run_move(b, 2'd1, bo, mv, sc, lat, da, ba);
        bus.board_in = rand_board();
        bus.dir      = 2'd0;
        bus.start    = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b expected 0", bus.done); end
        n_checks++; if (bus.board_out !== '0) begin n_fail++; $display("FAIL midrst_board_out: got %h expected 0", bus.board_out); end
        n_checks++; if (bus.moved !== 1'b0) begin n_fail++; $display("FAIL midrst_moved: got %b expected 0", bus.moved); end
        n_checks++; if (bus.score_add !== '0) begin n_fail++; $display("FAIL midrst_score: got %h expected 0", bus.score_add); end
        pulses = 0;
        for (int c = 0; c < N + 3; c++) begin
            if (bus.done === 1'b1) pulses++;
            step();
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL midrst_stray_done: got %0d expected 0", pulses); end
        b = rand_board();
        model(b, 2'd3, e, emv, esc);
        run_move(b, 2'd3, bo, mv, sc, lat, da, ba);
        n_checks++; if (bo !== e) begin n_fail++; $display("FAIL midrst_fresh_board: got %h expected %h", bo, e); end
        n_checks++; if (sc !== esc) begin n_fail++; $display("FAIL midrst_fresh_score: got %h expected %h", sc, esc); end
        n_checks++; if (lat !== N) begin n_fail++; $display("FAIL midrst_fresh_latency: got %0d expected %0d", lat, N); end
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dir      = 2'd0;
        bus.board_in = '0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_busy_ignore();
        test_rst_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
